// File: rtl/divu4_seq.sv
// Sequential unsigned 4-bit restoring divider, one quotient bit per cycle.
// Returns Q/R/DivZero with a one-cycle Done pulse; B=0 completes immediately.
module divu4_seq (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Start,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic       Busy,
    output logic       Done,
    output logic [3:0] Q,
    output logic [3:0] R,
    output logic       DivZero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [3:0] p_q, p_d;
    logic [3:0] q_q, q_d;
    logic [1:0] cnt_q, cnt_d;
    logic [3:0] quo_q, quo_d;
    logic [3:0] rem_q, rem_d;
    logic       dz_q, dz_d;

    logic [3:0] t;
    logic [3:0] diff;
    logic       bw;

    // p[3] is always 0 at a shift; folding it in keeps the borrow exact anyway
    always_comb begin
        t          = {p_q[2:0], a_q[3]};
        {bw, diff} = {p_q[3], t} - {1'b0, b_q};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        unique case (state_q)
            IDLE, FIN: begin
                state_d = IDLE;
                if (Start) begin
                    if (B == 4'd0) begin
                        state_d = FIN;
                        quo_d   = 4'hF;
                        rem_d   = A;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = RUN;
                        a_d     = A;
                        b_d     = B;
                        p_d     = 4'd0;
                        q_d     = 4'd0;
                        cnt_d   = 2'd0;
                    end
                end
            end
            RUN: begin
                p_d   = bw ? t : diff;
                q_d   = {q_q[2:0], ~bw};
                a_d   = {a_q[2:0], 1'b0};
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = FIN;
                    quo_d   = q_d;
                    rem_d   = p_d;
                    dz_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            a_q     <= 4'd0;
            b_q     <= 4'd0;
            p_q     <= 4'd0;
            q_q     <= 4'd0;
            cnt_q   <= 2'd0;
            quo_q   <= 4'd0;
            rem_q   <= 4'd0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end

    assign Busy    = (state_q == RUN);
    assign Done    = (state_q == FIN);
    assign Q       = quo_q;
    assign R       = rem_q;
    assign DivZero = dz_q;

endmodule

// File: tb/tb_divu4_seq.sv
// Directed and exhaustive bench for divu4_seq.
// Expected results are queued at Start and compared when Done appears.
module tb_divu4_seq;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic [3:0] A = 4'd0;
    logic [3:0] B = 4'd0;
    logic       Busy;
    logic       Done;
    logic [3:0] Q;
    logic [3:0] R;
    logic       DivZero;

    divu4_seq dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .Start  (Start),
        .A      (A),
        .B      (B),
        .Busy   (Busy),
        .Done   (Done),
        .Q      (Q),
        .R      (R),
        .DivZero(DivZero)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [3:0] q;
        logic [3:0] r;
        logic       dz;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   ndone = 0;
    int   last_done = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge Clock);
        #1;
        cyc++;
        chk("busy_done_excl", 32'(Busy & Done), 32'd0);
        if (Busy === 1'b1)
            chk("p3_zero", 32'(dut.p_q[3]), 32'd0);
        if (Done === 1'b1) begin
            ndone++;
            last_done = cyc;
            if (sb.size() == 0) begin
                chk("spurious_done", 32'(Done), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("q", 32'(Q), 32'(e.q));
                chk("r", 32'(R), 32'(e.r));
                chk("divzero", 32'(DivZero), 32'(e.dz));
            end
        end
    endtask

    function automatic exp_t model(input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        if (b == 4'd0) begin
            e.q  = 4'hF;
            e.r  = a;
            e.dz = 1'b1;
        end else begin
            e.q  = a / b;
            e.r  = a % b;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    task automatic run_op(input logic [3:0] a, input logic [3:0] b);
        int n = 0;
        int nb = 0;
        int d0;
        A     = a;
        B     = b;
        Start = 1'b1;
        sb.push_back(model(a, b));
        d0 = ndone;
        while (ndone == d0 && n < 12) begin
            tick();
            Start = 1'b0;
            n++;
            if (Busy === 1'b1) nb++;
        end
        chk("done_edge", 32'(n), (b == 4'd0) ? 32'd1 : 32'd5);
        chk("busy_cycles", 32'(nb), (b == 4'd0) ? 32'd0 : 32'd4);
    endtask

    initial begin
        int d0;
        int t0;
        int dc[3];

        // reset state
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_q", 32'(Q), 32'd0);
        chk("rst_r", 32'(R), 32'd0);
        chk("rst_dz", 32'(DivZero), 32'd0);

        // first op, then hold check
        run_op(4'd13, 4'd3);
        Start = 1'b0;
        tick();
        tick();
        chk("hold_done", 32'(Done), 32'd0);
        chk("hold_q", 32'(Q), 32'd4);
        chk("hold_r", 32'(R), 32'd1);

        run_op(4'd15, 4'd1);
        run_op(4'd14, 4'd15);
        run_op(4'd0, 4'd5);
        run_op(4'd7, 4'd0);
        run_op(4'd9, 4'd2);
        Start = 1'b0;
        tick();

        // Start and operand changes mid-run are ignored
        A     = 4'd15;
        B     = 4'd4;
        Start = 1'b1;
        sb.push_back(model(4'd15, 4'd4));
        t0 = cyc;
        tick();
        Start = 1'b0;
        chk("tog_busy", 32'(Busy), 32'd1);
        tick();
        A     = 4'd3;
        B     = 4'd1;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        A     = 4'd7;
        B     = 4'd9;
        tick();
        A = 4'd0;
        B = 4'd0;
        tick();
        chk("tog_done", 32'(Done), 32'd1);
        chk("tog_latency", 32'(last_done - t0), 32'd5);
        tick();
        chk("tog_no_second", 32'(Done), 32'd0);
        chk("tog_idle", 32'(Busy), 32'd0);

        // Start held: accepted in every FIN cycle
        A     = 4'd11;
        B     = 4'd2;
        Start = 1'b1;
        for (int k = 0; k < 3; k++) sb.push_back(model(4'd11, 4'd2));
        d0 = ndone;
        for (int k = 0; k < 20 && (ndone - d0) < 3; k++) begin
            tick();
            if (Done === 1'b1) dc[ndone - d0 - 1] = cyc;
        end
        Start = 1'b0;
        chk("cont_count", 32'(ndone - d0), 32'd3);
        chk("cont_gap1", 32'(dc[1] - dc[0]), 32'd5);
        chk("cont_gap2", 32'(dc[2] - dc[1]), 32'd5);
        tick();
        chk("cont_stop", 32'(Done), 32'd0);

        // reset mid-division
        A     = 4'd12;
        B     = 4'd5;
        Start = 1'b1;
        sb.push_back(model(4'd12, 4'd5));
        tick();
        Start = 1'b0;
        tick();
        Reset = 1'b1;
        Start = 1'b1;
        tick();
        sb.delete();
        chk("mrst_busy", 32'(Busy), 32'd0);
        chk("mrst_done", 32'(Done), 32'd0);
        chk("mrst_q", 32'(Q), 32'd0);
        chk("mrst_r", 32'(R), 32'd0);
        chk("mrst_dz", 32'(DivZero), 32'd0);
        Reset = 1'b0;
        Start = 1'b0;
        repeat (6) tick();
        chk("mrst_no_done", 32'(ndone), 32'(ndone));
        run_op(4'd12, 4'd5);
        Start = 1'b0;
        tick();

        // exhaustive sweep, back-to-back
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                run_op(4'(a), 4'(b));
        Start = 1'b0;
        tick();
        tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
